// File: rtl/betting_round_controller.sv
// betting_round_controller: runs one betting round and drives money manager commands; optional ACTION_TIMEOUT_EN adds an idle auto-action
module betting_round_controller #(
    parameter int MIN_RAISE      = 200,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_round,
    input  logic        first_pbet,
    input  logic        action_valid,
    input  logic [1:0]  action,
    input  logic [14:0] raise_amt,
    input  logic [14:0] money_player,
    input  logic [14:0] money_negreanu,
    input  logic [14:0] bet_player,
    input  logic [14:0] bet_negreanu,
    output logic        add_bet,
    output logic        pbet,
    output logic [14:0] value,
    output logic        add_pot,
    output logic        split_pot,
    output logic [1:0]  winID,
    output logic        turn_pbet,
    output logic        await_action,
    output logic        round_done,
    output logic        folded,
    output logic        all_in
);
    typedef enum logic [2:0] {IDLE, WAIT_ACT, ISSUE, SETTLE, EVAL, COLLECT, FOLDWIN, DONE} state_t;
    localparam logic [14:0] MIN_R = 15'(MIN_RAISE);
    state_t state_q, state_d;
    logic        turn_q, turn_d, folded_q, folded_d, all_in_q, all_in_d;
    logic [1:0]  acts_q, acts_d, acts_inc, act_eff;
    logic [14:0] value_q, value_d, own_bet, opp_bet, own_money, opp_money, to_call, inc, calc;
    logic [15:0] raise_sum;
    logic        act_go, over, collect;
    assign own_bet   = turn_q ? bet_player : bet_negreanu;
    assign opp_bet   = turn_q ? bet_negreanu : bet_player;
    assign own_money = turn_q ? money_player : money_negreanu;
    assign opp_money = turn_q ? money_negreanu : money_player;
    assign to_call   = opp_bet > own_bet ? opp_bet - own_bet : 15'd0;
    assign inc       = raise_amt > MIN_R ? raise_amt : MIN_R;
    assign raise_sum = {1'b0, to_call} + {1'b0, inc};
    assign calc      = act_eff == 2'd1 ? (to_call < own_money ? to_call : own_money) :
                       act_eff == 2'd2 ? (raise_sum > {1'b0, own_money} ? own_money : raise_sum[14:0]) :
                       own_money;
    assign over      = calc != 15'd0 && ({1'b0, own_bet} + {1'b0, calc}) > {1'b0, opp_bet};
    assign acts_inc  = acts_q == 2'd3 ? 2'd3 : acts_q + 2'd1;
    assign collect   = (bet_player == bet_negreanu && acts_q >= 2'd2) ||
                       (bet_player == bet_negreanu && (money_player == 15'd0 || money_negreanu == 15'd0)) ||
                       (own_bet < opp_bet && own_money == 15'd0) ||
                       (opp_money == 15'd0 && own_bet >= opp_bet);
`ifdef ACTION_TIMEOUT_EN
    logic [25:0] cnt_q, cnt_d;
    logic        tmo;
    assign tmo     = state_q == WAIT_ACT && cnt_q == 26'(TIMEOUT_CYCLES - 1) && !action_valid;
    assign act_go  = action_valid | tmo;
    assign act_eff = action_valid ? action : (to_call == 15'd0 ? 2'd1 : 2'd0);
    // idle counter runs only while waiting, so it is zero on every entry to WAIT_ACT
    always_comb begin
        cnt_d = state_q == WAIT_ACT ? cnt_q + 26'd1 : 26'd0;
    end
    // idle counter register
    always_ff @(posedge clock) begin
        if (reset) cnt_q <= 26'd0;
        else       cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign act_go  = action_valid;
    assign act_eff = action;
`endif
    // next-state and round bookkeeping
    always_comb begin
        state_d  = state_q;
        turn_d   = turn_q;
        acts_d   = acts_q;
        folded_d = folded_q;
        all_in_d = all_in_q;
        value_d  = value_q;
        case (state_q)
            IDLE: if (start_round) begin
                state_d  = WAIT_ACT;
                turn_d   = first_pbet;
                acts_d   = 2'd0;
                folded_d = 1'b0;
                all_in_d = 1'b0;
            end
            WAIT_ACT: if (act_go) begin
                if (act_eff == 2'd0) state_d = FOLDWIN;
                else begin
                    value_d = calc;
                    acts_d  = over ? 2'd1 : acts_inc;
                    state_d = calc == 15'd0 ? EVAL : ISSUE;
                end
            end
            ISSUE:   state_d = SETTLE;
            SETTLE:  state_d = EVAL;
            EVAL: begin
                state_d = collect ? COLLECT : WAIT_ACT;
                turn_d  = collect ? turn_q : ~turn_q;
            end
            COLLECT: begin
                all_in_d = money_player == 15'd0 || money_negreanu == 15'd0;
                state_d  = DONE;
            end
            FOLDWIN: begin
                folded_d = 1'b1;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state and bookkeeping registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            turn_q   <= 1'b0;
            acts_q   <= 2'd0;
            folded_q <= 1'b0;
            all_in_q <= 1'b0;
            value_q  <= 15'd0;
        end else begin
            state_q  <= state_d;
            turn_q   <= turn_d;
            acts_q   <= acts_d;
            folded_q <= folded_d;
            all_in_q <= all_in_d;
            value_q  <= value_d;
        end
    end
    assign add_bet      = state_q == ISSUE;
    assign pbet         = add_bet & turn_q;
    assign value        = value_q;
    assign add_pot      = state_q == COLLECT;
    assign split_pot    = state_q == FOLDWIN;
    assign winID        = split_pot ? (turn_q ? 2'd1 : 2'd2) : 2'd0;
    assign turn_pbet    = turn_q;
    assign await_action = state_q == WAIT_ACT;
    assign round_done   = state_q == DONE;
    assign folded       = folded_q;
    assign all_in       = all_in_q;
endmodule

// File: tb/tb_betting_round_controller.sv
// tb_betting_round_controller: directed and random betting rounds against a rule-level reference model
module tb_betting_round_controller;
    logic        clock = 1'b0, reset = 1'b1, start_round = 1'b0, first_pbet = 1'b0, action_valid = 1'b0;
    logic [1:0]  action = 2'd0;
    logic [14:0] raise_amt = 15'd0, money_player = 15'd0, money_negreanu = 15'd0;
    logic [14:0] bet_player = 15'd0, bet_negreanu = 15'd0;
    logic        add_bet, pbet, add_pot, split_pot, turn_pbet, await_action, round_done, folded, all_in;
    logic [14:0] value;
    logic [1:0]  winID;
    int total = 0, bad = 0;
    int m_bet[2], m_money[2], m_turn, m_acts;
    always #5 clock = ~clock;
    betting_round_controller #(.MIN_RAISE(200), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .start_round(start_round), .first_pbet(first_pbet),
        .action_valid(action_valid), .action(action), .raise_amt(raise_amt),
        .money_player(money_player), .money_negreanu(money_negreanu),
        .bet_player(bet_player), .bet_negreanu(bet_negreanu),
        .add_bet(add_bet), .pbet(pbet), .value(value), .add_pot(add_pot), .split_pot(split_pot),
        .winID(winID), .turn_pbet(turn_pbet), .await_action(await_action), .round_done(round_done),
        .folded(folded), .all_in(all_in));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    // one cycle; the money manager stand-in books any add_bet seen this cycle
    task automatic step();
        @(negedge clock);
        if (add_bet) begin
            if (pbet) begin
                bet_player   = bet_player + value;
                money_player = money_player - value;
            end else begin
                bet_negreanu   = bet_negreanu + value;
                money_negreanu = money_negreanu - value;
            end
        end
        action_valid = 1'b0;
        start_round  = 1'b0;
    endtask
    task automatic begin_round(input logic fp, input int mp, input int mn, input int bp, input int bn);
        money_player = 15'(mp); money_negreanu = 15'(mn);
        bet_player   = 15'(bp); bet_negreanu   = 15'(bn);
        m_money[1] = mp; m_money[0] = mn; m_bet[1] = bp; m_bet[0] = bn;
        m_turn = int'(fp); m_acts = 0;
        first_pbet  = fp;
        start_round = 1'b1;
        step();
        chk("start_await", await_action, 1);
        chk("start_turn", turn_pbet, fp);
        chk("start_folded", folded, 0);
        chk("start_allin", all_in, 0);
    endtask
    // outcome: 0 next turn, 1 pot collected, 2 fold
    task automatic do_action(input int a, input int r, output int outcome);
        int own, opp, tc, v, exp_out, got_out, n_bet, got_v, got_p, pots, splits, win, done, steps;
        bit eq, any0;
        own = m_turn; opp = 1 - m_turn;
        tc = m_bet[opp] > m_bet[own] ? m_bet[opp] - m_bet[own] : 0;
        v = 0;
        if (a == 1) v = tc < m_money[own] ? tc : m_money[own];
        if (a == 2) begin
            v = tc + (r > 200 ? r : 200);
            if (v > m_money[own]) v = m_money[own];
        end
        if (a == 3) v = m_money[own];
        if (a == 0) exp_out = 2;
        else begin
            if (v > 0) begin
                m_bet[own] += v;
                m_money[own] -= v;
                m_acts = m_bet[own] > m_bet[opp] ? 1 : m_acts + 1;
            end else m_acts++;
            eq   = m_bet[0] == m_bet[1];
            any0 = m_money[0] == 0 || m_money[1] == 0;
            exp_out = ((eq && m_acts >= 2) || (eq && any0) ||
                       (m_bet[own] < m_bet[opp] && m_money[own] == 0) ||
                       (m_money[opp] == 0 && m_bet[own] >= m_bet[opp])) ? 1 : 0;
        end
        chk("act_await", await_action, 1);
        chk("act_turn", turn_pbet, own);
        action_valid = 1'b1; action = 2'(a); raise_amt = 15'(r);
        n_bet = 0; got_v = 0; got_p = 0; pots = 0; splits = 0; win = 0; done = 0; steps = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            steps++;
            if (add_bet) begin n_bet++; got_v = value; got_p = pbet; end
            if (add_pot) pots++;
            if (split_pot) begin splits++; win = winID; end
            if (round_done) begin done = 1; break; end
            if (await_action) break;
        end
        got_out = pots > 0 ? 1 : splits > 0 ? 2 : await_action ? 0 : -1;
        chk("n_add_bet", n_bet, v > 0 ? 1 : 0);
        if (v > 0) begin
            chk("bet_value", got_v, v);
            chk("bet_pbet", got_p, own);
        end
        chk("outcome", got_out, exp_out);
        if (exp_out == 0) begin
            m_turn = opp;
            chk("next_turn", turn_pbet, m_turn);
            chk("latency_le4", steps <= 4, 1);
        end else begin
            chk("round_done", done, 1);
            if (exp_out == 2) begin
                chk("winID", win, own == 1 ? 1 : 2);
                chk("folded", folded, 1);
                chk("n_add_pot", pots, 0);
            end else begin
                chk("n_split", splits, 0);
                chk("all_in", all_in, (m_money[0] == 0 || m_money[1] == 0) ? 1 : 0);
                chk("not_folded", folded, 0);
            end
            step();
        end
        outcome = exp_out;
    endtask
    initial begin
        int o, n, hit;
        step(); step();
        chk("rst_await", await_action, 0);
        chk("rst_addbet", add_bet, 0);
        chk("rst_value", value, 0);
        reset = 1'b0;
        step();
        // player call then Negreanu check
        begin_round(1'b1, 9900, 9800, 100, 200);
        do_action(1, 0, o);
        do_action(1, 0, o);
        chk("t1_end", o, 1);
        // raise clamped to the minimum, then call
        begin_round(1'b1, 5000, 5000, 0, 0);
        do_action(2, 50, o);
        do_action(1, 0, o);
        chk("t2_end", o, 1);
        // check, raise, fold
        begin_round(1'b1, 5000, 5000, 0, 0);
        do_action(1, 0, o);
        do_action(2, 300, o);
        do_action(0, 0, o);
        chk("t3_end", o, 2);
        // short all-in call
        begin_round(1'b1, 150, 9600, 0, 400);
        do_action(1, 0, o);
        chk("t4_end", o, 1);
        // reset while the bet settles
        begin_round(1'b1, 1000, 1000, 0, 0);
        action_valid = 1'b1; action = 2'd2; raise_amt = 15'd0;
        step(); step();
        reset = 1'b1;
        step();
        chk("mid_rst_await", await_action, 0);
        chk("mid_rst_value", value, 0);
        chk("mid_rst_turn", turn_pbet, 0);
        chk("mid_rst_pulses", {add_bet, add_pot, split_pot, round_done, winID}, 0);
        reset = 1'b0;
        step();
        action_valid = 1'b1; action = 2'd3;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (add_bet || await_action) n++;
        end
        chk("idle_action_ignored", n, 0);
        // random rounds
        for (int g = 0; g < 30; g++) begin
            begin_round(1'($urandom_range(0, 1)), $urandom_range(50, 2000), $urandom_range(50, 2000),
                        $urandom_range(0, 300), $urandom_range(0, 300));
            for (int k = 0; k < 30; k++) begin
                n = $urandom_range(0, 9);
                do_action(n == 0 ? 0 : n < 5 ? 1 : n < 8 ? 2 : n == 8 ? 3 : 1, $urandom_range(0, 600), o);
                if (o != 0) break;
            end
            chk("rand_round_over", o != 0, 1);
        end
`ifdef ACTION_TIMEOUT_EN
        begin_round(1'b1, 1000, 1000, 0, 100);
        hit = 0;
        for (int i = 0; i < 20 && hit == 0; i++) begin
            step();
            if (split_pot) begin hit = 1; chk("tmo_winID", winID, 1); end
        end
        chk("tmo_fold", hit, 1);
        step(); step();
        chk("tmo_folded", folded, 1);
        begin_round(1'b0, 1000, 1000, 0, 0);
        hit = 0;
        for (int i = 0; i < 20 && hit == 0; i++) begin
            step();
            if (add_bet) chk("tmo_no_bet", add_bet, 0);
            if (await_action && turn_pbet) hit = 1;
        end
        chk("tmo_check_toggle", hit, 1);
        hit = 0;
        for (int i = 0; i < 20 && hit == 0; i++) begin
            step();
            if (add_pot) hit = 1;
        end
        chk("tmo_collect", hit, 1);
        step(); step();
`else
        begin_round(1'b1, 1000, 1000, 0, 100);
        for (int i = 0; i < 20; i++) step();
        chk("no_tmo_wait", await_action, 1);
        do_action(0, 0, o);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/betting_round_controller.md
Name: betting_round_controller

Overview:
Initiator side of the money manager command interface. Runs one betting round: accepts fold/check-call/raise/all-in actions from the player UI and the Negreanu AI, alternates turns, and issues add_bet/pbet/value, add_pot and split_pot/winID commands. Reads money_*/bet_* back from the money manager to compute call amounts and detect round end. Instantiated once per street by the game FSM.

Parameters:
MIN_RAISE, 200, minimum raise increment above the call amount (15-bit units)
TIMEOUT_CYCLES, 50000000, idle cycles before auto-action (only with ACTION_TIMEOUT_EN)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
start_round  input  1  one-cycle pulse; begins a round when idle
first_pbet  input  1  sampled on start_round; 1 = player acts first
action_valid  input  1  one-cycle pulse; action from the side whose turn it is
action  input  2  0 FOLD, 1 CHECK/CALL, 2 RAISE, 3 ALLIN
raise_amt  input  15  raise increment over the call amount
money_player, money_negreanu  input  15 each  stacks, from money manager
bet_player, bet_negreanu  input  15 each  current street bets, from money manager
add_bet  output  1  one-cycle command pulse
pbet  output  1  target of add_bet; 1 = player
value  output  15  amount for add_bet
add_pot  output  1  one-cycle pulse; sweeps bets into the pot
split_pot  output  1  one-cycle pulse; awards pot per winID
winID  output  2  1 Negreanu, 2 player; held with split_pot
turn_pbet  output  1  whose turn; 1 = player
await_action  output  1  high while waiting for action_valid
round_done  output  1  one-cycle pulse at end of round
folded  output  1  high from fold until next start_round
all_in  output  1  high from round end until next start_round if either stack is 0

Behaviour:
- Reset: state IDLE; all outputs 0. A reset mid-round abandons the round and issues no commands.
- States: IDLE -> WAIT_ACT -> ISSUE -> SETTLE -> EVAL -> (WAIT_ACT | COLLECT | FOLDWIN) -> DONE -> IDLE.
- IDLE:
  - On start_round: turn_pbet <= first_pbet, acts <= 0, folded <= 0, all_in <= 0; go to WAIT_ACT.
  - start_round outside IDLE is ignored.
- WAIT_ACT:
  - await_action = 1.
  - action_valid outside WAIT_ACT is ignored.
  - Definitions, with own and opp relative to turn_pbet: to_call = opp_bet > own_bet ? opp_bet - own_bet : 0. min(a,b) is unsigned 15-bit.
  - FOLD -> FOLDWIN.
  - CHECK/CALL: value = min(to_call, own_money).
  - RAISE: inc = max(raise_amt, MIN_RAISE); value = min(to_call + inc, own_money). Compute the sum at 16 bits, then saturate.
  - ALLIN: value = own_money.
  - If the computed value is 0 (check): no add_bet; acts++ ; go to EVAL.
  - Otherwise go to ISSUE.
- ISSUE: add_bet = 1 for one cycle; pbet = turn_pbet; value held. Go to SETTLE.
- SETTLE: wait one cycle so the money manager's registered outputs reflect the bet.
- acts update: if the action put own_bet strictly above opp_bet, acts <= 1; otherwise acts++.
- EVAL: bets are now current. Go to COLLECT if any of these hold:
  - bet_player == bet_negreanu and acts >= 2;
  - bet_player == bet_negreanu and either stack is 0;
  - the actor's bet < opponent bet and actor money == 0 (short all-in call; no side pot);
  - opponent money == 0 and actor bet >= opponent bet.
  Otherwise toggle turn_pbet and return to WAIT_ACT.
- COLLECT: add_pot = 1 for one cycle. all_in <= (either stack == 0). Go to DONE.
- FOLDWIN: split_pot = 1 for one cycle; winID = turn_pbet ? 1 : 2; folded <= 1. Go to DONE.
- DONE: round_done = 1 for one cycle; go to IDLE.
- Command pulses are mutually exclusive and never occur on consecutive cycles. Worst-case action-to-next-await latency is 4 cycles.

Optional Feature:
ACTION_TIMEOUT_EN:
- Defined: a 26-bit counter clears on entry to WAIT_ACT and increments each cycle in WAIT_ACT. When it reaches TIMEOUT_CYCLES-1 with no action_valid, an internal action is substituted: CHECK/CALL if to_call == 0, otherwise FOLD. An action_valid in the same cycle takes priority.
- Undefined: no counter; the controller waits indefinitely.

Test Plan:
- Stacks 9900/9800, bets player 100, Negreanu 200, first_pbet = 1; player CALL then Negreanu CHECK -> add_bet pbet=1 value=100, no second add_bet, add_pot pulse, round_done, all_in=0.
- Bets 0/0; player RAISE raise_amt=50 -> value=200 (clamped to MIN_RAISE). Negreanu CALL -> value=200, then add_pot.
- Bets 0/0; player CHECK, Negreanu RAISE 300, player FOLD -> split_pot with winID=1, folded=1, no add_pot.
- Player money 150, bets 0/400; player CALL -> value=150, EVAL goes directly to COLLECT, all_in=1.
- Reset asserted in SETTLE -> next cycle IDLE, all outputs 0; action_valid while IDLE produces no add_bet.
- With ACTION_TIMEOUT_EN, TIMEOUT_CYCLES=8, to_call=100 and no action -> FOLD substituted on cycle 8, split_pot with winID per turn; with to_call=0 -> auto-check, turn toggles.
